rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) stage and a multi-cycle long-latency unit (LU, e.g. mul/div).
- Buffers one LU result and prevents LU starvation.
- Keeps a 32-entry busy scoreboard of outstanding LU destinations, so decode stalls on RAW/WAW hazards.
- Sits between the WB stage, the LU and the register file write port (we/WriteN/In). The register file writes on negedge.

Parameters:
- MAX_WAIT, 4: cycles a buffered LU result may be denied the port before forced grant; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  WB stage write request
- pipe_rd  in  5  WB destination register
- pipe_data  in  32  WB write data
- lu_issue  in  1  LU accepts a new op this cycle
- lu_issue_rd  in  5  destination of the issued LU op
- lu_valid  in  1  LU result valid
- lu_rd  in  5  LU result destination
- lu_data  in  32  LU result data
- lu_ready  out  1  arbiter can accept an LU result
- dec_rs1  in  5  decode source 1
- dec_rs2  in  5  decode source 2
- dec_rd  in  5  decode destination
- hazard_stall  out  1  decode must stall
- wb_stall  out  1  WB stage must hold its write this cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data

Behaviour:
- State:
  - hold_valid/hold_rd/hold_data: 1-entry LU result buffer.
  - wait_cnt: 4-bit counter.
  - busy[31:0]: scoreboard.
- Reset (async, rst_n=0): hold_valid=0, wait_cnt=0, busy=0. With idle inputs: lu_ready=1, rf_we=0, hazard_stall=0, wb_stall=0. Reset mid-operation discards the buffered result and clears all busy bits.
- lu_ready = !hold_valid. On lu_valid && lu_ready (rising clk), capture lu_rd/lu_data and set hold_valid. LU must hold lu_valid/data until accepted.
- Grant (combinational, same cycle):
  - force = hold_valid && wait_cnt==MAX_WAIT.
  - hold_grant = hold_valid && (force || !pipe_we || pipe_rd==0).
  - If hold_grant: rf_we=1, rf_waddr=hold_rd, rf_wdata=hold_data.
  - Else: rf_we = pipe_we && pipe_rd!=0, address/data from pipe.
- wb_stall = force && pipe_we && pipe_rd!=0. WB holds its write and retries next cycle; the pipe write is never lost by the arbiter.
- wait_cnt:
  - 0 when !hold_valid or hold_grant.
  - Otherwise increments, saturating at MAX_WAIT.
- hold_valid clears on hold_grant at clk. A new LU result can be accepted no earlier than the following cycle (lu_ready low while full). Minimum LU result-to-write latency is 1 cycle.
- Scoreboard:
  - On lu_issue && lu_issue_rd!=0, set busy[lu_issue_rd].
  - On hold_grant, clear busy[hold_rd].
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is always 0.
- hazard_stall = hit(dec_rs1) | hit(dec_rs2) | hit(dec_rd), where hit(r) = r!=0 && busy[r] (subject to the optional feature below).
- Results with lu_rd==0: hold_grant still occurs (consumes a slot), rf_we=0, no busy change.

Optional Feature:
- Macro RF_WB_SAME_CYCLE_CLEAR_EN.
- Defined: hit(r) excludes r==hold_rd when hold_grant is 1. Decode is released in the retiring cycle, which is legal because the register file writes on negedge before the next posedge read.
- Undefined: hit(r) uses the registered busy only; release is 1 cycle later.

Test Plan:
- Reset with rst_n=0 mid-buffer (hold_valid=1, busy[5]=1) -> hold_valid=0, busy=0, lu_ready=1, rf_we=0 immediately (async).
- Idle WB, lu_valid=1 lu_rd=7 lu_data=32'hDEAD_BEEF -> next cycle rf_we=1 rf_waddr=7 rf_wdata=32'hDEAD_BEEF, lu_ready low for exactly that cycle.
- WB writes x3 every cycle with an LU result buffered for x9 and MAX_WAIT=4 -> 4 pipe writes, then a cycle with wb_stall=1 and rf_waddr=9, then the pipe x3 write resumes unchanged.
- lu_issue rd=12, then dec_rs2=12 -> hazard_stall=1 until the x12 result retires. Release is in the retire cycle with RF_WB_SAME_CYCLE_CLEAR_EN, one cycle later without.
- Same cycle: retire x4 and lu_issue rd=4 -> busy[4] stays 1, hazard_stall for dec_rs1=4 remains asserted.
- lu_issue rd=0 and LU result rd=0 -> busy unchanged, rf_we=0, hazard_stall=0 for dec_rs1=0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Bundles the WB, LU, decode and register-file write signals around rf_wb_arbiter.
// The slave modport is the arbiter's view and the master modport is the surrounding pipeline's view.
interface rf_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard_stall;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
    input  dec_rs1, dec_rs2, dec_rd,
    output lu_ready, hazard_stall, wb_stall,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
    output dec_rs1, dec_rs2, dec_rd,
    input  lu_ready, hazard_stall, wb_stall,
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between WB and a buffered long-latency unit result.
// It also tracks outstanding LU destinations for decode. Define RF_WB_SAME_CYCLE_CLEAR_EN to release decode in the retire cycle.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  rf_wb_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic        r_hold_valid;
  logic [4:0]  r_hold_rd;
  logic [31:0] r_hold_data;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_busy;

  logic        w_force;
  logic        w_hold_grant;
  logic        w_pipe_wr;
  logic [31:0] w_busy_nxt;
  logic [31:0] w_busy_vis;

  function automatic logic hit(input logic [4:0] r, input logic [31:0] b);
    return (r != 5'd0) && b[r];
  endfunction

  assign w_force      = r_hold_valid && (r_wait_cnt == MAX_WAIT_C);
  assign w_pipe_wr    = bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign w_hold_grant = r_hold_valid && (w_force || !w_pipe_wr);

  assign bus.lu_ready = !r_hold_valid;
  assign bus.wb_stall = w_force && w_pipe_wr;

  // A granted x0 result still uses the write slot, but never writes the register file.
  always_comb begin
    if (w_hold_grant) begin
      bus.rf_we    = (r_hold_rd != 5'd0);
      bus.rf_waddr = r_hold_rd;
      bus.rf_wdata = r_hold_data;
    end else begin
      bus.rf_we    = w_pipe_wr;
      bus.rf_waddr = bus.pipe_rd;
      bus.rf_wdata = bus.pipe_data;
    end
  end

  // A new issue to the register that is retiring in this cycle keeps its busy bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_hold_grant)
      w_busy_nxt[r_hold_rd] = 1'b0;
    if (bus.lu_issue && (bus.lu_issue_rd != 5'd0))
      w_busy_nxt[bus.lu_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_busy_vis = r_busy;
`ifdef RF_WB_SAME_CYCLE_CLEAR_EN
    // The register file writes on negedge, so decode can read the retiring value at the next posedge.
    if (w_hold_grant)
      w_busy_vis[r_hold_rd] = 1'b0;
`endif
  end

  assign bus.hazard_stall = hit(bus.dec_rs1, w_busy_vis) |
                            hit(bus.dec_rs2, w_busy_vis) |
                            hit(bus.dec_rd,  w_busy_vis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_rd    <= 5'd0;
      r_hold_data  <= 32'd0;
      r_wait_cnt   <= 4'd0;
      r_busy       <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_hold_grant)
        r_hold_valid <= 1'b0;
      else if (!r_hold_valid && bus.lu_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_rd    <= bus.lu_rd;
        r_hold_data  <= bus.lu_data;
      end
      if (!r_hold_valid || w_hold_grant)
        r_wait_cnt <= 4'd0;
      else if (r_wait_cnt != MAX_WAIT_C)
        r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter with MAX_WAIT=4.
// Expected values are hand-derived per cycle; the release cycle depends on RF_WB_SAME_CYCLE_CLEAR_EN.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RF_WB_SAME_CYCLE_CLEAR_EN
  localparam logic RETIRE_STALL = 1'b0;
`else
  localparam logic RETIRE_STALL = 1'b1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_we     = 1'b0;
    bus.pipe_rd     = 5'd0;
    bus.pipe_data   = 32'd0;
    bus.lu_issue    = 1'b0;
    bus.lu_issue_rd = 5'd0;
    bus.lu_valid    = 1'b0;
    bus.lu_rd       = 5'd0;
    bus.lu_data     = 32'd0;
    bus.dec_rs1     = 5'd0;
    bus.dec_rs2     = 5'd0;
    bus.dec_rd      = 5'd0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_hazard", 32'(bus.hazard_stall), 32'd0);
    check("rst_wb_stall", 32'(bus.wb_stall), 32'd0);
    rst_n = 1'b1;

    // LU result into an idle write port
    tick();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'hDEAD_BEEF;
    #1 check("lu7_ready_before", 32'(bus.lu_ready), 32'd1);
    tick();
    bus.lu_valid = 1'b0;
    #1;
    check("lu7_rf_we", 32'(bus.rf_we), 32'd1);
    check("lu7_waddr", 32'(bus.rf_waddr), 32'd7);
    check("lu7_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    check("lu7_ready_full", 32'(bus.lu_ready), 32'd0);
    tick();
    #1;
    check("lu7_ready_after", 32'(bus.lu_ready), 32'd1);
    check("lu7_rf_we_after", 32'(bus.rf_we), 32'd0);

    // WB writes x3 every cycle; buffered x9 is forced in after MAX_WAIT denials
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h0000_0033;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h0000_0099;
    #1 check("starve_pre_waddr", 32'(bus.rf_waddr), 32'd3);
    tick();
    bus.lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("starve_pipe%0d_waddr", i), 32'(bus.rf_waddr), 32'd3);
      check($sformatf("starve_pipe%0d_wb_stall", i), 32'(bus.wb_stall), 32'd0);
      tick();
    end
    #1;
    check("starve_force_wb_stall", 32'(bus.wb_stall), 32'd1);
    check("starve_force_waddr", 32'(bus.rf_waddr), 32'd9);
    check("starve_force_wdata", bus.rf_wdata, 32'h0000_0099);
    tick();
    #1;
    check("starve_resume_waddr", 32'(bus.rf_waddr), 32'd3);
    check("starve_resume_wdata", bus.rf_wdata, 32'h0000_0033);
    check("starve_resume_wb_stall", 32'(bus.wb_stall), 32'd0);
    check("starve_resume_ready", 32'(bus.lu_ready), 32'd1);
    bus.pipe_we = 1'b0; bus.pipe_rd = 5'd0;

    // Scoreboard hazard on x12 until it retires
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd12;
    tick();
    bus.lu_issue = 1'b0; bus.dec_rs2 = 5'd12;
    #1 check("x12_stall0", 32'(bus.hazard_stall), 32'd1);
    tick();
    #1 check("x12_stall1", 32'(bus.hazard_stall), 32'd1);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd12; bus.lu_data = 32'h1200_0012;
    tick();
    bus.lu_valid = 1'b0;
    #1;
    check("x12_retire_we", 32'(bus.rf_we), 32'd1);
    check("x12_retire_stall", 32'(bus.hazard_stall), 32'(RETIRE_STALL));
    tick();
    #1 check("x12_after_stall", 32'(bus.hazard_stall), 32'd0);
    bus.dec_rs2 = 5'd0;

    // Retire x4 while re-issuing x4: set wins
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd4;
    tick();
    bus.lu_issue = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd4; bus.lu_data = 32'h4444_4444;
    tick();
    bus.lu_valid = 1'b0;
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd4; bus.dec_rs1 = 5'd4;
    #1;
    check("x4_retire_waddr", 32'(bus.rf_waddr), 32'd4);
    check("x4_retire_stall", 32'(bus.hazard_stall), 32'(RETIRE_STALL));
    tick();
    bus.lu_issue = 1'b0;
    #1 check("x4_still_busy", 32'(bus.hazard_stall), 32'd1);
    tick();
    #1 check("x4_still_busy2", 32'(bus.hazard_stall), 32'd1);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd4; bus.lu_data = 32'h4444_0000;
    tick();
    bus.lu_valid = 1'b0;
    tick();
    #1 check("x4_cleared", 32'(bus.hazard_stall), 32'd0);
    bus.dec_rs1 = 5'd0;

    // x0 destination: slot consumed, no write, no busy
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd0;
    tick();
    bus.lu_issue = 1'b0;
    #1 check("x0_issue_stall", 32'(bus.hazard_stall), 32'd0);
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'h5A5A_5A5A;
    #1 check("x0_pipe_we", 32'(bus.rf_we), 32'd0);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'h5555_5555;
    tick();
    bus.lu_valid = 1'b0;
    #1;
    check("x0_result_we", 32'(bus.rf_we), 32'd0);
    check("x0_result_ready", 32'(bus.lu_ready), 32'd0);
    check("x0_result_wb_stall", 32'(bus.wb_stall), 32'd0);
    tick();
    #1 check("x0_ready_after", 32'(bus.lu_ready), 32'd1);
    bus.pipe_we = 1'b0;

    // Reset mid-buffer: hold x6 behind WB writes with x5 busy
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd5;
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h0000_0033;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd6; bus.lu_data = 32'h6666_6666;
    tick();
    bus.lu_issue = 1'b0; bus.lu_valid = 1'b0; bus.dec_rs1 = 5'd5;
    #1;
    check("mid_ready_full", 32'(bus.lu_ready), 32'd0);
    check("mid_stall", 32'(bus.hazard_stall), 32'd1);
    bus.pipe_we = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.lu_ready), 32'd1);
    check("mid_rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("mid_rst_stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("post_rst_stall", 32'(bus.hazard_stall), 32'd0);
    check("post_rst_rf_we", 32'(bus.rf_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
